rtc_lectura: RTL

//  Register reader for the external RTC on the multiplexed AD/CS/RD/WR bus.
//  It is the read-side counterpart of the RTC initialisation sequencer.
//  On start, it runs NUM_REGS address-write + data-read transactions from FIRST_ADDR upward.

---
 rtl/rtc_lectura.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/rtc_lectura.sv
// ---------------------------------------------------------------------------
// rtc_lectura
//   Register reader for the external RTC on the multiplexed AD/CS/RD/WR bus.
//   This is the read-side counterpart of the RTC initialisation sequencer.
//   A start request runs NUM_REGS transactions from FIRST_ADDR upward. Each
//   transaction writes an address and then reads back a data byte. Each
//   captured byte is presented on data_out/data_idx with a one-cycle
//   data_valid strobe.
//
// Ports
//   clock       in   1  system clock
//   reset       in   1  synchronous, active-low
//   start       in   1  begin a burst; sampled only in IDLE
//   ADin        in   8  AD bus read-back from the pad
//   cs          out  1  RTC chip select, active-low
//   ad          out  1  address/data select (0 = address, 1 = data)
//   rd          out  1  read strobe, active-low
//   wr          out  1  write strobe, active-low
//   ADout       out  8  AD bus drive value, 8'hFF when not driving
//   ad_oe       out  1  pad output enable for ADout (0 = tristate)
//   data_out    out  8  last captured register byte
//   data_idx    out  3  register index of data_out
//   data_valid  out  1  one-cycle strobe: data_out/data_idx are new
//   busy        out  1  burst in progress
//   done        out  1  one-cycle pulse at burst end
// ---------------------------------------------------------------------------
module rtc_lectura #(
   parameter logic [7:0] FIRST_ADDR = 8'h21,
   parameter int         NUM_REGS   = 7,
   parameter int         PULSE_CYC  = 5,
   parameter int         GAP_CYC    = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] ADin,
   output logic       cs,
   output logic       ad,
   output logic       rd,
   output logic       wr,
   output logic [7:0] ADout,
   output logic       ad_oe,
   output logic [7:0] data_out,
   output logic [2:0] data_idx,
   output logic       data_valid,
   output logic       busy,
   output logic       done
);

   localparam int                CNT_W      = 16;
   localparam logic [CNT_W-1:0]  CNT_ONE    = 1;
   localparam logic [CNT_W-1:0]  PULSE_LAST = CNT_W'(PULSE_CYC - 1);
   localparam logic [CNT_W-1:0]  GAP_LAST   = CNT_W'(GAP_CYC - 1);
   localparam logic [2:0]        IDX_LAST   = 3'(NUM_REGS - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_A_AD,
      S_A_CS,
      S_A_WR,
      S_A_DRV,
      S_A_WRH,
      S_A_CSH,
      S_A_ADH,
      S_A_GAP,
      S_R_CS,
      S_R_RD,
      S_R_RDH,
      S_R_CSH,
      S_R_GAP,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic       cs_q, cs_d;
   logic       ad_q, ad_d;
   logic       rd_q, rd_d;
   logic       wr_q, wr_d;
   logic [7:0] adout_q, adout_d;
   logic       ad_oe_q, ad_oe_d;
   logic [7:0] data_out_q, data_out_d;
   logic [2:0] data_idx_q, data_idx_d;
   logic       data_valid_q, data_valid_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;

   // Next-state logic. cnt_d defaults to zero so that every multi-cycle
   // state starts counting from zero on entry. It only advances while the
   // FSM stays in the same state.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = '0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_A_AD;
               idx_d   = 3'd0;
            end
         end
         S_A_AD:  state_d = S_A_CS;
         S_A_CS:  state_d = S_A_WR;
         S_A_WR:  state_d = S_A_DRV;
         S_A_DRV: begin
            if (cnt_q == PULSE_LAST) state_d = S_A_WRH;
            else                     cnt_d   = cnt_q + CNT_ONE;
         end
         S_A_WRH: state_d = S_A_CSH;
         S_A_CSH: state_d = S_A_ADH;
         S_A_ADH: state_d = S_A_GAP;
         S_A_GAP: begin
            if (cnt_q == GAP_LAST) state_d = S_R_CS;
            else                   cnt_d   = cnt_q + CNT_ONE;
         end
         S_R_CS:  state_d = S_R_RD;
         S_R_RD: begin
            if (cnt_q == PULSE_LAST) state_d = S_R_RDH;
            else                     cnt_d   = cnt_q + CNT_ONE;
         end
         S_R_RDH: state_d = S_R_CSH;
         S_R_CSH: state_d = S_R_GAP;
         S_R_GAP: begin
            if (cnt_q == GAP_LAST) begin
               if (idx_q == IDX_LAST) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_A_AD;
                  idx_d   = idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode. Outputs are decoded from the next state and registered
   // alongside it, so each output carries its listed value while the FSM
   // is in that state.
   always_comb begin
      cs_d  = !(state_d inside {S_A_CS, S_A_WR, S_A_DRV, S_A_WRH,
                                S_R_CS, S_R_RD, S_R_RDH});
      ad_d  = !(state_d inside {S_A_AD, S_A_CS, S_A_WR, S_A_DRV,
                                S_A_WRH, S_A_CSH});
      wr_d  = !(state_d inside {S_A_WR, S_A_DRV});
      rd_d  = (state_d != S_R_RD);
      ad_oe_d = (state_d inside {S_A_DRV, S_A_WRH});
      // 8-bit sum: the address wraps from 8'hFF to 8'h00.
      adout_d = ad_oe_d ? (FIRST_ADDR + {5'b00000, idx_d}) : 8'hFF;

      data_valid_d = (state_d == S_R_RDH);
      data_idx_d   = data_valid_d ? idx_d : data_idx_q;
      // ADin is sampled only on the edge that leaves R_RD.
      data_out_d   = (state_q == S_R_RD && state_d == S_R_RDH) ? ADin : data_out_q;

      busy_d = !(state_d inside {S_IDLE, S_DONE});
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         idx_q        <= 3'd0;
         cnt_q        <= '0;
         cs_q         <= 1'b1;
         ad_q         <= 1'b1;
         rd_q         <= 1'b1;
         wr_q         <= 1'b1;
         adout_q      <= 8'hFF;
         ad_oe_q      <= 1'b0;
         data_out_q   <= 8'h00;
         data_idx_q   <= 3'd0;
         data_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         cs_q         <= cs_d;
         ad_q         <= ad_d;
         rd_q         <= rd_d;
         wr_q         <= wr_d;
         adout_q      <= adout_d;
         ad_oe_q      <= ad_oe_d;
         data_out_q   <= data_out_d;
         data_idx_q   <= data_idx_d;
         data_valid_q <= data_valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign cs         = cs_q;
   assign ad         = ad_q;
   assign rd         = rd_q;
   assign wr         = wr_q;
   assign ADout      = adout_q;
   assign ad_oe      = ad_oe_q;
   assign data_out   = data_out_q;
   assign data_idx   = data_idx_q;
   assign data_valid = data_valid_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule
